// File: rtl/pcore_interface_defs.sv
// Shared data-bus protocol types and responder constants.
// Used by the interconnect and every peripheral responder.
package pcore_interface_defs;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  sel_byte;
        logic        req;
        logic        w_en;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;

    localparam int DBUS_RESP_WS_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } type_dbus_resp_states_e;

    // Expand a 4-bit byte select into a 32-bit lane mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dbus_byte_merge.sv
// Byte-lane merge of bus data, hardware data and the old value.
// Bus lanes win; hardware fills the rest when enabled.
module dbus_byte_merge
    import pcore_interface_defs::*;
(
    input  logic [31:0] old_val,
    input  logic [31:0] bus_data,
    input  logic [3:0]  bus_sel,
    input  logic [31:0] hw_data,
    input  logic        hw_en,
    output logic [31:0] merged
);

    logic [31:0] base;
    logic [31:0] mask;

    assign base   = hw_en ? hw_data : old_val;
    assign mask   = byte_mask(bus_sel);
    assign merged = (bus_data & mask) | (base & ~mask);

endmodule

// File: rtl/dbus_reg_responder.sv
// Peripheral-side data-bus responder with a 32-bit register bank.
// Captures a request, waits WAIT_STATES cycles, then writes or reads and acks.
module dbus_reg_responder
    import pcore_interface_defs::*;
#(
    parameter int                     NUM_REGS    = 8,
    parameter int                     WAIT_STATES = 1,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL   = '0,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  type_dbus2peri_s          dbus2peri_i,
    input  logic                     sel_i,
    output type_peri2dbus_s          peri2dbus_o,
    output logic [NUM_REGS*32-1:0]   regs_o,
    input  logic                     hw_we_i,
    input  logic [IDX_W-1:0]         hw_idx_i,
    input  logic [31:0]              hw_data_i,
    output logic [NUM_REGS-1:0]      bus_wr_pulse_o
);

    // Last counter value spent in WAIT before moving to RESP.
    localparam logic [3:0] WS_LAST =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    type_dbus_resp_states_e state_q, state_d;

    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [3:0]       sel_q;
    logic [31:0]      rdata_q, rdata_d;

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] merged [NUM_REGS];

    logic [NUM_REGS-1:0] bus_hit;
    logic [NUM_REGS-1:0] hw_hit;

    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_we;
    logic [31:0]      rd_val;
    logic             capture;
    logic             enter_resp;

    // Byte-offset and upper address bits carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{dbus2peri_i.addr[31:IDX_W+2],
                           dbus2peri_i.addr[1:0]};

    assign req_idx = dbus2peri_i.addr[IDX_W+1:2];
    assign capture = (state_q == IDLE) & sel_i & dbus2peri_i.req;

    // State, wait counter and captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (capture) begin
                idx_q   <= req_idx;
                we_q    <= dbus2peri_i.w_en;
                wdata_q <= dbus2peri_i.w_data;
                sel_q   <= dbus2peri_i.sel_byte;
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    cnt_d = '0;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WS_LAST) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read mux; out-of-range indices fall through to zero.
    always_comb begin
        rd_idx = (state_q == IDLE) ? req_idx : idx_q;
        rd_we  = (state_q == IDLE) ? dbus2peri_i.w_en : we_q;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
        rdata_d = (enter_resp && !rd_we) ? rd_val : 32'd0;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign bus_hit[i] = (state_q == RESP) & we_q
                          & (idx_q == IDX_W'(i));
        assign hw_hit[i]  = hw_we_i & (hw_idx_i == IDX_W'(i));

        dbus_byte_merge u_merge (
            .old_val  (regs_q[i]),
            .bus_data (wdata_q),
            .bus_sel  (sel_q & {4{bus_hit[i]}}),
            .hw_data  (hw_data_i),
            .hw_en    (hw_hit[i]),
            .merged   (merged[i])
        );

        assign regs_o[32*i +: 32] = regs_q[i];
    end

    // Register bank update from the merged bus/hardware values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL[32*i +: 32];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= merged[i];
            end
        end
    end

    assign bus_wr_pulse_o = bus_hit;
    assign peri2dbus_o    = '{r_data: rdata_q, ack: (state_q == RESP)};

endmodule

// File: doc/dbus_reg_responder.md
Name: dbus_reg_responder

Overview:
- Generic peripheral-side responder for the data bus: the target end of the `type_dbus2peri_s` / `type_peri2dbus_s` protocol that the dbus interconnect drives.
- Each peripheral instantiates one: the responder registers the request, counts configurable wait states, then performs a byte-masked write or a registered read on a bank of 32-bit registers and pulses ack.
- It also exposes the register bank to the peripheral core and accepts hardware-side updates.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; word index = addr[IDX_W+1:2], IDX_W = $clog2(NUM_REGS).
- WAIT_STATES, 1, extra cycles between request capture and ack (0..15).
- RESET_VAL, '0, per-register reset value (NUM_REGS*32-bit vector, register i at [32*i+:32]).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- dbus2peri_i  in  type_dbus2peri_s  addr, w_data, sel_byte, req, w_en from the interconnect.
- sel_i  in  1  module select from the interconnect address decoder.
- peri2dbus_o  out  type_peri2dbus_s  r_data and ack back to the interconnect.
- regs_o  out  NUM_REGS*32  current register contents.
- hw_we_i  in  1  hardware write strobe.
- hw_idx_i  in  IDX_W  hardware write register index.
- hw_data_i  in  32  hardware write data (full word).
- bus_wr_pulse_o  out  NUM_REGS  one-hot, high for the one cycle a bus write commits to register i.

Behaviour:
- One clock (clk), one reset (rst): asynchronous, active-high.
- Reset values: FSM in IDLE; peri2dbus_o.ack=0; r_data=0; bus_wr_pulse_o=0; regs_o=RESET_VAL; wait counter=0.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: if sel_i & req, capture addr index, w_en, w_data, sel_byte and clear the counter.
  - WAIT_STATES==0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: increment the counter. When counter==WAIT_STATES-1, go to RESP.
  - Dropping req or sel_i during WAIT does not abort; the captured transaction completes.
- RESP: ack=1 for exactly one cycle, then IDLE.
  - Write: each captured sel_byte[b] set writes w_data[8b+:8] into the register on the RESP clock edge. bus_wr_pulse_o[idx]=1 in RESP.
  - Read: r_data holds the register value sampled on entering RESP, valid while ack=1, and 0 in every other cycle.
- Latency: request sampled at edge N gives ack high during cycle N+1+WAIT_STATES.
- Requester contract: req must drop in the cycle after ack. A req still high in IDLE after RESP is a new transaction.
- Out-of-range index (idx >= NUM_REGS, only possible for non-power-of-2 NUM_REGS):
  - ack is still generated, with r_data=0.
  - Write is dropped and no bus_wr_pulse_o bit is set.
- sel_byte==0 on a write: ack is generated and no bytes change; bus_wr_pulse_o still pulses.
- Address bits [1:0] are ignored, because lanes are already aligned by the interconnect.
- Hardware and bus write to the same register on the same edge: bus bytes with sel_byte set win; the remaining bytes take hw_data_i.
- Hardware write to a different register on the same edge: both commit.
- hw_idx_i out of range: ignored.
- Read in RESP with hw_we_i active on the same register: r_data returns the pre-edge value, because it was sampled on RESP entry.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, ack deasserts, and the pending write is lost.

Decomposition:
- pcore_interface_defs package (existing): `type_dbus2peri_s` and `type_peri2dbus_s`.
- pcore_interface_defs package (new): `DBUS_RESP_WS_MAX` = 15 constant and enum `type_dbus_resp_states_e` {IDLE, WAIT, RESP}.
- Sub-module `dbus_byte_merge`: combinational 32-bit merge of bus bytes (sel_byte), hw_data, and the old value. It is reused per register in a generate loop.

Test Plan:
- Reset: assert rst mid-simulation → regs_o==RESET_VAL, ack=0 and r_data=0 asynchronously, before the next clk edge.
- WAIT_STATES=1, word write addr=0x8, w_data=0xDEADBEEF, sel_byte=4'b1111 → ack at cycle N+2, regs_o[2]==0xDEADBEEF, bus_wr_pulse_o==8'b00000100.
- Byte write to reg 2 (previously 0xDEADBEEF), addr=0x9, w_data=0x0000AA00, sel_byte=4'b0010 → reg 2 ==0xDEADAAEF; then a read of 0x8 gives r_data=0xDEADAAEF with ack, and r_data=0 the following cycle.
- WAIT_STATES=0 read of reg 1 (RESET_VAL 0x12345678) → ack in cycle N+1 with r_data=0x12345678; req held for 2 extra cycles → second ack at N+3.
- Collision: bus write addr=0x0, sel_byte=4'b0001, w_data=0x000000FF, with hw_we_i=1, hw_idx_i=0, hw_data_i=0x11223344 on the same edge → reg 0 ==0x112233FF.
- Abort robustness: WAIT_STATES=3, drop req and sel_i one cycle after capture → ack still asserted at N+4 and the write commits; rst asserted during WAIT → no ack and the register is unchanged.
